// File: rtl/led_mode_sequencer.sv
// Push-switch LED mode sequencer: debounce, OFF/SLOW/FAST/ON stepping and blink generation.
// Optional feature: define LED_PWM_DIM_EN to dim the ON mode with a PWM counter.
module led_mode_sequencer #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SLOW_BIT        = 24,
    parameter int FAST_BIT        = 22,
    parameter int PWM_BITS        = 4,
    parameter int PWM_DUTY        = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       switch,
    output logic       LED,
    output logic [1:0] mode,
    output logic       press
);

    localparam int CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int PRESC_W = SLOW_BIT + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        MODE_OFF  = 2'd0,
        MODE_SLOW = 2'd1,
        MODE_FAST = 2'd2,
        MODE_ON   = 2'd3
    } mode_t;

    logic               sync1_q, sync2_q;
    logic [CNT_W-1:0]   dbCount_q, dbCount_d;
    logic               db_q, db_d;
    logic               dbPrev_q;
    logic               press_q, press_d;
    mode_t              mode_q, mode_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               led_q, led_d;
    logic               dbRise;
`ifdef LED_PWM_DIM_EN
    logic [PWM_BITS-1:0] pwmCnt_q, pwmCnt_d;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            dbCount_q <= '0;
            db_q      <= 1'b0;
            dbPrev_q  <= 1'b0;
            press_q   <= 1'b0;
            mode_q    <= MODE_OFF;
            presc_q   <= '0;
            led_q     <= 1'b0;
`ifdef LED_PWM_DIM_EN
            pwmCnt_q  <= '0;
`endif
        end else begin
            sync1_q   <= switch;
            sync2_q   <= sync1_q;
            dbCount_q <= dbCount_d;
            db_q      <= db_d;
            dbPrev_q  <= db_q;
            press_q   <= press_d;
            mode_q    <= mode_d;
            presc_q   <= presc_d;
            led_q     <= led_d;
`ifdef LED_PWM_DIM_EN
            pwmCnt_q  <= pwmCnt_d;
`endif
        end
    end

    always_comb begin
        dbCount_d = '0;
        db_d      = db_q;
        dbRise    = db_q & ~dbPrev_q;
        press_d   = dbRise;
        mode_d    = mode_q;
        led_d     = 1'b0;

        // Any cycle where the synced level agrees with db restarts the window.
        if (sync2_q != db_q) begin
            if (dbCount_q == CNT_MAX) begin
                db_d = sync2_q;
            end else begin
                dbCount_d = dbCount_q + CNT_W'(1);
            end
        end

        if (dbRise) begin
            case (mode_q)
                MODE_OFF:  mode_d = MODE_SLOW;
                MODE_SLOW: mode_d = MODE_FAST;
                MODE_FAST: mode_d = MODE_ON;
                default:   mode_d = MODE_OFF;
            endcase
        end

        // Restarting the prescaler on a mode change makes every blink begin dark.
        presc_d = dbRise ? '0 : presc_q + PRESC_W'(1);
`ifdef LED_PWM_DIM_EN
        pwmCnt_d = dbRise ? '0 : pwmCnt_q + PWM_BITS'(1);
`endif

        case (mode_q)
            MODE_OFF:  led_d = 1'b0;
            MODE_SLOW: led_d = presc_q[SLOW_BIT];
            MODE_FAST: led_d = presc_q[FAST_BIT];
            default: begin
`ifdef LED_PWM_DIM_EN
                led_d = (32'(pwmCnt_q) < $unsigned(PWM_DUTY));
`else
                led_d = 1'b1;
`endif
            end
        endcase
    end

    assign LED   = led_q;
    assign mode  = mode_q;
    assign press = press_q;

endmodule

// File: tb/tb_led_mode_sequencer.sv
// Directed self-checking bench for led_mode_sequencer with small debounce/prescaler parameters.
// Build with or without LED_PWM_DIM_EN; the ON-mode expectation follows the same macro.
module tb_led_mode_sequencer;

    localparam int N        = 8;
    localparam int SLOW_BIT = 4;
    localparam int FAST_BIT = 2;
    localparam int PWM_BITS = 2;
    localparam int PWM_DUTY = 1;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       sw    = 1'b0;
    logic       LED;
    logic [1:0] mode;
    logic       press;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    led_mode_sequencer #(
        .DEBOUNCE_CYCLES(N),
        .SLOW_BIT       (SLOW_BIT),
        .FAST_BIT       (FAST_BIT),
        .PWM_BITS       (PWM_BITS),
        .PWM_DUTY       (PWM_DUTY)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .switch(sw),
        .LED   (LED),
        .mode  (mode),
        .press (press)
    );

    // One active edge, then settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected LED k edges after the edge that changed the mode to m.
    function automatic logic exp_led(input logic [1:0] m, input int k);
        case (m)
            2'd0: return 1'b0;
            2'd1: return (((k - 1) / 16) % 2) == 1;
            2'd2: return (((k - 1) / 4) % 2) == 1;
            default: begin
`ifdef LED_PWM_DIM_EN
                return ((k - 1) % 4) == 0;
`else
                return 1'b1;
`endif
            end
        endcase
    endfunction

    task automatic pulse_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // Raise the switch and stop just after the edge where the press is due.
    task automatic raise_to_press();
        sw = 1'b1;
        repeat (N + 3) tick();
    endtask

    task automatic release_switch();
        sw = 1'b0;
        repeat (N + 4) tick();
    endtask

    task automatic test_reset();
        sw    = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        checks++;
        if (mode !== 2'd0) begin
            errors++;
            $display("[TB] FAIL reset_mode: got %0d expected 0", mode);
        end
        checks++;
        if (LED !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_led: got %b expected 0", LED);
        end
        checks++;
        if (press !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_press: got %b expected 0", press);
        end
        for (int c = 1; c <= 100; c++) begin
            tick();
            checks++;
            if (press !== 1'b0 || mode !== 2'd0 || LED !== 1'b0) begin
                errors++;
                $display("[TB] FAIL idle cycle %0d: press=%b mode=%0d LED=%b expected 0/0/0",
                         c, press, mode, LED);
            end
        end
    endtask

    task automatic test_single_press();
        sw = 1'b1;
        for (int e = 1; e <= N + 2; e++) begin
            tick();
            checks++;
            if (press !== 1'b0 || mode !== 2'd0) begin
                errors++;
                $display("[TB] FAIL early_press edge %0d: press=%b mode=%0d expected 0/0",
                         e, press, mode);
            end
        end
        tick();
        checks++;
        if (press !== 1'b1) begin
            errors++;
            $display("[TB] FAIL press_latency: got %b expected 1 after edge %0d", press, N + 3);
        end
        checks++;
        if (mode !== 2'd1) begin
            errors++;
            $display("[TB] FAIL mode_after_press: got %0d expected 1", mode);
        end
        for (int k = 1; k <= 48; k++) begin
            tick();
            checks++;
            if (LED !== exp_led(2'd1, k) || press !== 1'b0 || mode !== 2'd1) begin
                errors++;
                $display("[TB] FAIL slow_blink k=%0d: LED=%b press=%b mode=%0d expected %b/0/1",
                         k, LED, press, mode, exp_led(2'd1, k));
            end
        end
        release_switch();
        checks++;
        if (mode !== 2'd1) begin
            errors++;
            $display("[TB] FAIL release_mode: got %0d expected 1", mode);
        end
    endtask

    task automatic test_bounce();
        for (int e = 1; e <= 26; e++) begin
            sw = (e == 6) ? 1'b0 : 1'b1;
            tick();
            checks++;
            if (press !== (e == 17) || mode !== ((e >= 17) ? 2'd2 : 2'd1)) begin
                errors++;
                $display("[TB] FAIL bounce edge %0d: press=%b mode=%0d expected %b/%0d",
                         e, press, mode, (e == 17), (e >= 17) ? 2 : 1);
            end
        end
        release_switch();
        checks++;
        if (mode !== 2'd2) begin
            errors++;
            $display("[TB] FAIL bounce_release_mode: got %0d expected 2", mode);
        end
    endtask

    task automatic test_glitch();
        // Seven cycles high is one short of the window and must be ignored.
        for (int e = 1; e <= 30; e++) begin
            sw = (e <= 7);
            tick();
            checks++;
            if (press !== 1'b0 || mode !== 2'd2) begin
                errors++;
                $display("[TB] FAIL glitch7 edge %0d: press=%b mode=%0d expected 0/2", e, press, mode);
            end
        end
        // Exactly eight cycles high is just long enough.
        for (int e = 1; e <= 30; e++) begin
            sw = (e <= 8);
            tick();
            checks++;
            if (press !== (e == 11) || mode !== ((e >= 11) ? 2'd3 : 2'd2)) begin
                errors++;
                $display("[TB] FAIL pulse8 edge %0d: press=%b mode=%0d expected %b/%0d",
                         e, press, mode, (e == 11), (e >= 11) ? 3 : 2);
            end
        end
    endtask

    task automatic test_four_presses();
        logic [1:0] expMode;
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            expMode = 2'((i + 1) % 4);
            raise_to_press();
            checks++;
            if (press !== 1'b1 || mode !== expMode) begin
                errors++;
                $display("[TB] FAIL step%0d_press: press=%b mode=%0d expected 1/%0d",
                         i + 1, press, mode, expMode);
            end
            for (int k = 1; k <= 40; k++) begin
                tick();
                checks++;
                if (LED !== exp_led(expMode, k) || press !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL step%0d_led k=%0d: LED=%b press=%b expected %b/0",
                             i + 1, k, LED, press, exp_led(expMode, k));
                end
            end
            release_switch();
            checks++;
            if (mode !== expMode) begin
                errors++;
                $display("[TB] FAIL step%0d_hold_mode: got %0d expected %0d", i + 1, mode, expMode);
            end
        end
    endtask

    task automatic test_reset_mid_fast();
        pulse_reset();
        raise_to_press();
        release_switch();
        raise_to_press();
        release_switch();
        checks++;
        if (mode !== 2'd2) begin
            errors++;
            $display("[TB] FAIL reach_fast: got %0d expected 2", mode);
        end
        // Seven edges into a new press leaves the debounce count at 5.
        sw = 1'b1;
        repeat (7) tick();
        pulse_reset();
        checks++;
        if (mode !== 2'd0 || LED !== 1'b0 || press !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_state: mode=%0d LED=%b press=%b expected 0/0/0",
                     mode, LED, press);
        end
        for (int k = 1; k <= N + 2; k++) begin
            tick();
            checks++;
            if (press !== 1'b0 || mode !== 2'd0 || LED !== 1'b0) begin
                errors++;
                $display("[TB] FAIL midreset_window k=%0d: press=%b mode=%0d LED=%b expected 0/0/0",
                         k, press, mode, LED);
            end
        end
        tick();
        checks++;
        if (press !== 1'b1 || mode !== 2'd1) begin
            errors++;
            $display("[TB] FAIL midreset_press: press=%b mode=%0d expected 1/1", press, mode);
        end
        release_switch();
    endtask

    initial begin
        $display("[TB] led_mode_sequencer directed test start");
        test_reset();
        test_single_press();
        test_bounce();
        test_glitch();
        test_four_presses();
        test_reset_mid_fast();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
